pe_accum_ctrl: RTL and testbench
================================

// Module: pe_accum_ctrl
// PURPOSE
//  Clocked sequencer that sits directly upstream of the PE psum merge and feeds its select channel.
//  - Per output pixel, one token on the merge-select channel each accumulation step:
//    0 = fresh psum path (L0), 1 = adder loopback (L1).
//  - In the same step, one token on a split-select channel for the splitter after the adder:
//    0 = feed back, 1 = emit result.
//  - Repeats for a configured number of outputs, then pulses done.
// PARAMETERS
//  CNT_W    8  width of the accumulation-count and output-count configuration and counters
//  MAX_ACC  255  largest legal cfg_num_acc; larger values saturate to MAX_ACC
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      one-cycle request to begin a job; ignored while busy=1
//  cfg_num_acc  in   CNT_W  accumulations per output, latched on an accepted start
//  cfg_num_out  in   CNT_W  outputs per job, latched on an accepted start
//  msel_valid   out  1      merge-select token valid
//  msel_ready   in   1      merge consumer accepts the token
//  msel_data    out  1      merge select: 0 = L0, 1 = L1
//  ssel_valid   out  1      split-select token valid
//  ssel_ready   in   1      split consumer accepts the token
//  ssel_data    out  1      split select: 0 = loopback, 1 = output
//  busy         out  1      job in progress (RUN state)
//  out_done     out  1      one-cycle pulse when the last step of an output has completed
//  job_done     out  1      one-cycle pulse when the job has finished
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; all counters 0; all valids, data, busy and pulses 0.
//  - Handshake: a token transfers on a rising edge with valid&&ready.
//    - A valid stays high and its data stays stable until the token is accepted.
//    - Valid never depends combinationally on ready.
//  - Step k of output j (k = 0..A-1, j = 0..N-1), A = latched num_acc, N = latched num_out:
//    msel_data = (k != 0); ssel_data = (k == A-1).
//  - Each step loads both slots in the same cycle. The two slots drain independently: both in one
//    cycle, or in either order across cycles.
//  - The step retires on the cycle its last pending token is accepted. The next step's tokens are
//    valid from the following cycle, so the steady state is 1 step per 2 cycles.
//  - States:
//    - IDLE: start=1 latches config, clears k and j, and then:
//      - N==0 -> DONE (no tokens);
//      - else -> RUN with step 0 loaded.
//    - RUN: on step retire:
//      - k < A-1: k++.
//      - k == A-1: out_done=1, k=0, then j < N-1 -> j++, or j == N-1 -> DONE.
//    - DONE: job_done=1 for exactly one cycle -> IDLE. busy=0.
//  - Boundaries:
//    - A == 0 is treated as A = 1, giving msel=0, ssel=1 every step.
//    - A == 1: each step carries both msel=0 and ssel=1.
//    - start in RUN or DONE is ignored; the latched config is unaffected by cfg_* changes.
//    - Counters never wrap: the terminal compare happens before the increment.
//    - Indefinite back-pressure on either channel holds the other slot's accepted state, with no
//      duplicate or lost token.
//    - Reset mid-job aborts immediately: tokens are dropped and no done pulses are issued.
// STRUCTURE
//  - pe_pkg:
//    - typedef enum {IDLE, RUN, DONE} acc_state_e;
//    - localparam SEL_L0 = 1'b0, SEL_L1 = 1'b1, SPLIT_FB = 1'b0, SPLIT_OUT = 1'b1.
//  - Sub-module pe_token_slot (1-bit, 1-entry valid/ready holding register, async active-low reset).
//    - Instantiated twice: msel and ssel.
//    - Ports: load, load_data, valid, ready, data, empty.
//  - Top: FSM plus k/j counters; the retire condition is a function of both slots' empty signals.
// TESTING
//  - Reset: rst_n=0 mid-RUN -> all outputs 0 immediately; after release, state IDLE.
//  - Basic, A=3 N=2, readies tied 1:
//    - msel 0,1,1,0,1,1 and ssel 0,0,1,0,0,1;
//    - out_done after steps 3 and 6; job_done 1 cycle later.
//  - Skew: A=2 N=1, ssel_ready=0 for 5 cycles.
//    - msel token 0 accepted once;
//    - step 2 is not issued until ssel is accepted;
//    - no duplicate msel token.
//  - Edge configs:
//    - A=0 N=2 -> two steps, each msel=0 ssel=1.
//    - N=0 -> no tokens, job_done one cycle after start.
//  - Start while busy: second start with different cfg during RUN -> ignored; token sequence
//    matches the first cfg.
//  - Random ready stalls on both channels, A=4 N=3 -> scoreboard counts exactly 12 tokens per
//    channel in the correct pattern.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and select encodings for the PE accumulation sequencer.
// Imported by the token slot and the accumulation controller.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } acc_state_e;

    localparam logic SEL_L0    = 1'b0;
    localparam logic SEL_L1    = 1'b1;
    localparam logic SPLIT_FB  = 1'b0;
    localparam logic SPLIT_OUT = 1'b1;

endpackage

// File: rtl/pe_token_slot.sv
// One-entry, one-bit valid/ready holding register.
// A loaded token is held stable until the consumer accepts it.
module pe_token_slot
    import pe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_data,
    output logic valid,
    input  logic ready,
    output logic data,
    output logic empty
);

    logic valid_q, valid_d;
    logic data_q, data_d;

    // Next-state: a load fills the slot, an accepted token empties it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign empty = !valid_q;

endmodule

// File: rtl/pe_accum_ctrl.sv
// Merge/split select sequencer for the PE psum accumulation loop.
// Issues one merge-select and one split-select token per accumulation step.
module pe_accum_ctrl
    import pe_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MAX_ACC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_acc,
    input  logic [CNT_W-1:0] cfg_num_out,
    output logic             msel_valid,
    input  logic             msel_ready,
    output logic             msel_data,
    output logic             ssel_valid,
    input  logic             ssel_ready,
    output logic             ssel_data,
    output logic             busy,
    output logic             out_done,
    output logic             job_done
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_A = CNT_W'(MAX_ACC);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] j_q, j_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] nout_q, nout_d;
    logic [CNT_W-1:0] acc_eff;
    logic [CNT_W-1:0] k_inc;

    logic load;
    logic m_ld_data, s_ld_data;
    logic m_empty, s_empty;
    logic retire, last_k, last_j;

    pe_token_slot u_msel (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (m_ld_data),
        .valid     (msel_valid),
        .ready     (msel_ready),
        .data      (msel_data),
        .empty     (m_empty)
    );

    pe_token_slot u_ssel (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (s_ld_data),
        .valid     (ssel_valid),
        .ready     (ssel_ready),
        .data      (ssel_data),
        .empty     (s_empty)
    );

    // Effective accumulation count: zero behaves as one, large values clamp.
    always_comb begin
        acc_eff = cfg_num_acc;
        if (32'(cfg_num_acc) > MAX_ACC) begin
            acc_eff = MAX_A;
        end
        if (cfg_num_acc == '0) begin
            acc_eff = ONE;
        end
    end

    // A step retires once both of its tokens have left their slots.
    assign retire   = (state_q == RUN) && m_empty && s_empty;
    assign last_k   = (k_q == acc_q - ONE);
    assign last_j   = (j_q == nout_q - ONE);
    assign k_inc    = k_q + ONE;
    assign out_done = retire && last_k;
    assign busy     = (state_q == RUN);
    assign job_done = (state_q == DONE);

    // Sequencer: latch config, walk k within j, load each step's tokens.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        j_d       = j_q;
        acc_d     = acc_q;
        nout_d    = nout_q;
        load      = 1'b0;
        m_ld_data = SEL_L0;
        s_ld_data = SPLIT_FB;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d  = acc_eff;
                    nout_d = cfg_num_out;
                    k_d    = '0;
                    j_d    = '0;
                    if (cfg_num_out == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        load      = 1'b1;
                        m_ld_data = SEL_L0;
                        s_ld_data = (acc_eff == ONE) ? SPLIT_OUT : SPLIT_FB;
                    end
                end
            end
            RUN: begin
                if (retire) begin
                    if (!last_k) begin
                        k_d       = k_inc;
                        load      = 1'b1;
                        m_ld_data = SEL_L1;
                        s_ld_data = (k_inc == acc_q - ONE) ? SPLIT_OUT : SPLIT_FB;
                    end else begin
                        k_d = '0;
                        if (last_j) begin
                            state_d = DONE;
                        end else begin
                            j_d       = j_q + ONE;
                            load      = 1'b1;
                            m_ld_data = SEL_L0;
                            s_ld_data = (acc_q == ONE) ? SPLIT_OUT : SPLIT_FB;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            nout_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            nout_q  <= nout_d;
        end
    end

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// Directed bench for pe_accum_ctrl with a token scoreboard.
// Expected select tokens are queued at launch and popped on each handshake.
module tb_pe_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_num_acc = '0;
    logic [7:0] cfg_num_out = '0;
    logic       msel_valid, msel_data;
    logic       ssel_valid, ssel_data;
    logic       msel_ready = 1'b1;
    logic       ssel_ready = 1'b1;
    logic       busy, out_done, job_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_a = 1;
    int cur_n = 0;
    int m_job_cnt = 0;
    int s_job_cnt = 0;
    int od_cnt = 0;
    int jd_cnt = 0;
    int jd_cyc = 0;
    int start_cyc = 0;
    int jd0 = 0;
    logic prev_od = 1'b0;
    logic rand_rdy = 1'b0;
    logic mq[$];
    logic sq[$];

    pe_accum_ctrl #(.CNT_W(8), .MAX_ACC(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_num_acc (cfg_num_acc),
        .cfg_num_out (cfg_num_out),
        .msel_valid  (msel_valid),
        .msel_ready  (msel_ready),
        .msel_data   (msel_data),
        .ssel_valid  (ssel_valid),
        .ssel_ready  (ssel_ready),
        .ssel_data   (ssel_data),
        .busy        (busy),
        .out_done    (out_done),
        .job_done    (job_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor at the falling edge: handshakes that will fire at the next rise.
    always @(negedge clk) begin
        if (msel_valid && msel_ready) begin
            chk("msel_expected", 32'(mq.size() > 0), 1);
            if (mq.size() > 0) chk("msel_data", 32'(msel_data), 32'(mq.pop_front()));
            m_job_cnt++;
        end
        if (ssel_valid && ssel_ready) begin
            chk("ssel_expected", 32'(sq.size() > 0), 1);
            if (sq.size() > 0) chk("ssel_data", 32'(ssel_data), 32'(sq.pop_front()));
            s_job_cnt++;
        end
        if (out_done) begin
            chk("od_msel_pos", m_job_cnt, (od_cnt + 1) * cur_a);
            chk("od_ssel_pos", s_job_cnt, (od_cnt + 1) * cur_a);
            od_cnt++;
        end
        if (job_done) begin
            chk("jd_after_od", 32'(prev_od), 32'(cur_n != 0));
            jd_cnt++;
            jd_cyc = cyc;
        end
        prev_od = out_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            msel_ready = 1'($urandom_range(0, 1));
            ssel_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic launch(input int a, input int n);
        int ae;
        ae = (a == 0) ? 1 : a;
        cur_a = ae;
        cur_n = n;
        m_job_cnt = 0;
        s_job_cnt = 0;
        od_cnt = 0;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < ae; k++) begin
                mq.push_back(k != 0);
                sq.push_back(k == ae - 1);
            end
        end
        cfg_num_acc = a[7:0];
        cfg_num_out = n[7:0];
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        int j0;
        n = 0;
        j0 = jd_cnt;
        while (jd_cnt == j0 && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_no_timeout"}, 32'(jd_cnt != j0), 1);
        chk({tag, "_mq_empty"}, mq.size(), 0);
        chk({tag, "_sq_empty"}, sq.size(), 0);
        chk({tag, "_msel_cnt"}, m_job_cnt, cur_a * cur_n);
        chk({tag, "_ssel_cnt"}, s_job_cnt, cur_a * cur_n);
        chk({tag, "_od_cnt"}, od_cnt, cur_n);
        step();
        chk({tag, "_idle_after"}, 32'({busy, job_done, msel_valid, ssel_valid}), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({msel_valid, msel_data, ssel_valid, ssel_data,
                                  busy, out_done, job_done}), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 32'(busy), 0);

        launch(3, 2);
        chk("basic_busy", 32'(busy), 1);
        wait_done("basic");

        msel_ready = 1'b1;
        ssel_ready = 1'b0;
        launch(2, 1);
        repeat (4) step();
        chk("skew_msel_once", m_job_cnt, 1);
        chk("skew_ssel_none", s_job_cnt, 0);
        chk("skew_valids", 32'({msel_valid, ssel_valid}), 32'(2'b01));
        ssel_ready = 1'b1;
        wait_done("skew");

        launch(0, 2);
        wait_done("a0");

        launch(1, 3);
        wait_done("a1");

        launch(0, 0);
        wait_done("n0");
        chk("n0_jd_cycle", jd_cyc, start_cyc + 1);

        launch(3, 2);
        step();
        step();
        chk("busy_before_restart", 32'(busy), 1);
        cfg_num_acc = 8'd5;
        cfg_num_out = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_num_acc = 8'd0;
        cfg_num_out = 8'd0;
        wait_done("restart_ignored");

        rand_rdy = 1'b1;
        launch(4, 3);
        wait_done("rand");
        rand_rdy = 1'b0;
        msel_ready = 1'b1;
        ssel_ready = 1'b1;

        launch(3, 2);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_out", 32'({msel_valid, msel_data, ssel_valid, ssel_data,
                                     busy, out_done, job_done}), 0);
        mq.delete();
        sq.delete();
        jd0 = jd_cnt;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("midrun_reset_idle", 32'({busy, msel_valid, ssel_valid}), 0);
        chk("midrun_reset_no_jd", jd_cnt, jd0);

        launch(1, 1);
        wait_done("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
